// File: rtl/avg_pool_pkg.sv
// ----------------------------------------------------------------------------
// avg_pool_pkg : state encoding and window-geometry helpers for avg_pool_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package avg_pool_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    FIRE = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam int DEF_KER_SIZE = 7;
  localparam int WIN_ELEMS    = DEF_KER_SIZE * DEF_KER_SIZE;

  function automatic int win_elems(input int ker_size);
    return ker_size * ker_size;
  endfunction

  // A 1x1 window still needs a 1-bit index so the port never collapses to zero width.
  function automatic int elem_idx_w(input int ker_size);
    int n;
    n = ker_size * ker_size;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avg_pool_ctrl_if.sv
// ----------------------------------------------------------------------------
// avg_pool_ctrl_if : job, beat-stream, datapath and result handshakes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface avg_pool_ctrl_if
  import avg_pool_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = DEF_KER_SIZE,
  parameter int CNT_W    = 16
);
  localparam int ACT_W = NFMAPS * NBITS * win_elems(KER_SIZE);

  logic                     start;
  logic [CNT_W-1:0]         num_windows;
  logic                     busy;
  logic                     done;
  logic                     in_valid;
  logic                     in_ready;
  logic [NFMAPS*NBITS-1:0]  in_data;
  logic                     pool_valid;
  logic [ACT_W-1:0]         pool_act;
  logic                     pool_ready;
  logic [NFMAPS*NBITS-1:0]  pool_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [NFMAPS*NBITS-1:0]  out_data;

  modport slave (
    input  start, num_windows, in_valid, in_data, pool_ready, pool_result, out_ready,
    output busy, done, in_ready, pool_valid, pool_act, out_valid, out_data
  );

  modport master (
    output start, num_windows, in_valid, in_data, pool_ready, pool_result, out_ready,
    input  busy, done, in_ready, pool_valid, pool_act, out_valid, out_data
  );

endinterface

`default_nettype wire

// File: rtl/avg_pool_win_buf.sv
// ----------------------------------------------------------------------------
// avg_pool_win_buf : scatters one beat into element i_idx of every fmap window
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avg_pool_win_buf
  import avg_pool_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = DEF_KER_SIZE,
  parameter int IDX_W    = elem_idx_w(KER_SIZE)
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic                                  i_we,
  input  wire logic [IDX_W-1:0]                      i_idx,
  input  wire logic [NFMAPS*NBITS-1:0]               i_data,
  output logic [NFMAPS*NBITS*win_elems(KER_SIZE)-1:0] o_act
);
  localparam int WIN = win_elems(KER_SIZE);

  logic [NFMAPS*NBITS*WIN-1:0] r_act;

  // Layout: fmap f, element e lives at word (f*WIN + e).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act <= '0;
    end else if (i_we) begin
      for (int f = 0; f < NFMAPS; f++) begin
        for (int e = 0; e < WIN; e++) begin
          if (i_idx == IDX_W'(e)) begin
            r_act[(f*WIN+e)*NBITS +: NBITS] <= i_data[f*NBITS +: NBITS];
          end
        end
      end
    end
  end

  assign o_act = r_act;

endmodule

`default_nettype wire

// File: rtl/avg_pool_ctrl.sv
// ----------------------------------------------------------------------------
// avg_pool_ctrl : collects windows, fires the average-pool datapath, returns results
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = DEF_KER_SIZE,
  parameter int CNT_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  avg_pool_ctrl_if.slave     bus
);
  localparam int              WIN      = win_elems(KER_SIZE);
  localparam int              IDX_W    = elem_idx_w(KER_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

  state_t                       r_state;
  state_t                       w_next;
  logic [IDX_W-1:0]             r_idx;
  logic [CNT_W-1:0]             r_win_cnt;
  logic [CNT_W-1:0]             r_num_win;
  logic [CNT_W-1:0]             w_cnt_inc;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_out_valid;
  logic [NFMAPS*NBITS-1:0]      r_out_data;
  logic [NFMAPS*NBITS*WIN-1:0]  w_act;
  logic                         w_accept;
  logic                         w_last_win;
  logic                         w_in_ready;
  logic                         w_pool_valid;

  assign w_accept   = (r_state == FILL) && bus.in_valid;
  assign w_cnt_inc  = r_win_cnt + CNT_W'(1);
  assign w_last_win = (w_cnt_inc == r_num_win);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_in_ready   = 1'b0;
    w_pool_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && (bus.num_windows != '0)) begin
          w_next = FILL;
        end
      end
      FILL: begin
        w_in_ready = 1'b1;
        if (w_accept && (r_idx == LAST_IDX)) begin
          w_next = FIRE;
        end
      end
      FIRE: begin
        w_pool_valid = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (bus.pool_ready) begin
          w_next = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          w_next = w_last_win ? IDLE : FILL;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A zero-window job only produces the done pulse; it never leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_idx       <= '0;
      r_win_cnt   <= '0;
      r_num_win   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_windows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_num_win <= bus.num_windows;
              r_busy    <= 1'b1;
            end
          end
        end
        FILL: begin
          if (w_accept) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
          end
        end
        WAIT: begin
          if (bus.pool_ready) begin
            r_out_data  <= bus.pool_result;
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_win) begin
              r_win_cnt <= '0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_win_cnt <= w_cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  avg_pool_win_buf #(
    .NBITS    (NBITS),
    .NFMAPS   (NFMAPS),
    .KER_SIZE (KER_SIZE),
    .IDX_W    (IDX_W)
  ) u_win_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_accept),
    .i_idx  (r_idx),
    .i_data (bus.in_data),
    .o_act  (w_act)
  );

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.in_ready   = w_in_ready;
  assign bus.pool_valid = w_pool_valid;
  assign bus.pool_act   = w_act;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_avg_pool_ctrl.sv
// ----------------------------------------------------------------------------
// tb_avg_pool_ctrl : directed + randomized bench with a registered averaging datapath
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_avg_pool_ctrl;
  localparam int NBITS  = 8;
  localparam int NFMAPS = 2;
  localparam int KER    = 2;
  localparam int CNT_W  = 16;
  localparam int WIN    = KER * KER;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pv_count    = 0;
  int   done_count  = 0;

  logic [NBITS-1:0] beat [WIN][NFMAPS];

  always #5 clk = ~clk;

  avg_pool_ctrl_if #(.NBITS(NBITS), .NFMAPS(NFMAPS), .KER_SIZE(KER), .CNT_W(CNT_W)) bus ();

  avg_pool_ctrl #(.NBITS(NBITS), .NFMAPS(NFMAPS), .KER_SIZE(KER), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int floor_avg(input int sum);
    return (sum >= 0) ? sum / WIN : -((-sum + WIN - 1) / WIN);
  endfunction

  // Registered datapath: result one cycle after the fire pulse.
  always @(posedge clk or posedge rst) begin
    int s;
    if (rst) begin
      bus.pool_ready  <= 1'b0;
      bus.pool_result <= '0;
    end else begin
      bus.pool_ready <= bus.pool_valid;
      if (bus.pool_valid) begin
        for (int f = 0; f < NFMAPS; f++) begin
          s = 0;
          for (int e = 0; e < WIN; e++)
            s += int'($signed(bus.pool_act[(f*WIN+e)*NBITS +: NBITS]));
          bus.pool_result[f*NBITS +: NBITS] <= NBITS'(floor_avg(s));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pool_valid) pv_count++;
      if (bus.done)       done_count++;
    end
  end

  function automatic logic [NFMAPS*NBITS-1:0] exp_out();
    logic [NFMAPS*NBITS-1:0] r;
    int s;
    for (int f = 0; f < NFMAPS; f++) begin
      s = 0;
      for (int e = 0; e < WIN; e++) s += int'($signed(beat[e][f]));
      r[f*NBITS +: NBITS] = NBITS'(floor_avg(s));
    end
    return r;
  endfunction

  function automatic logic [NFMAPS*NBITS*WIN-1:0] exp_act();
    logic [NFMAPS*NBITS*WIN-1:0] a;
    for (int f = 0; f < NFMAPS; f++)
      for (int e = 0; e < WIN; e++) a[(f*WIN+e)*NBITS +: NBITS] = beat[e][f];
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_window();
    for (int e = 0; e < WIN; e++)
      for (int f = 0; f < NFMAPS; f++) beat[e][f] = NBITS'($urandom_range(0, 255));
  endtask

  task automatic start_job(input int n);
    bus.start       = 1'b1;
    bus.num_windows = CNT_W'(n);
    tick();
    bus.start       = 1'b0;
    bus.num_windows = CNT_W'($urandom);
  endtask

  task automatic send_beats(input int maxgap, input int nbeats);
    logic acc;
    for (int e = 0; e < nbeats; e++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) tick();
      bus.in_valid = 1'b1;
      for (int f = 0; f < NFMAPS; f++) bus.in_data[f*NBITS +: NBITS] = beat[e][f];
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = bus.in_ready;
        tick();
      end
      if (!acc) check("beat_accept_timeout", 64'(acc), 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50 && !bus.out_valid; k++) tick();
    check("out_valid_arrives", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic finish_window(input int hold, input bit last);
    logic [NFMAPS*NBITS-1:0] held;
    int pvs;
    held = exp_out();
    pvs  = pv_count;
    check("out_data", 64'(bus.out_data), 64'(held));
    bus.out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data",  64'(bus.out_data),  64'(held));
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
    end
    check("bp_no_refire", 64'(pv_count), 64'(pvs));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hs_out_valid_low", 64'(bus.out_valid), 64'd0);
    check("hs_done",          64'(bus.done),      64'(last));
    check("hs_busy",          64'(bus.busy),      64'(!last));
  endtask

  initial begin
    int pvs;
    int dcs;
    bus.start       = 1'b0;
    bus.num_windows = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",       64'(bus.busy),       64'd0);
    check("rst_done",       64'(bus.done),       64'd0);
    check("rst_in_ready",   64'(bus.in_ready),   64'd0);
    check("rst_pool_valid", 64'(bus.pool_valid), 64'd0);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_data",   64'(bus.out_data),   64'd0);
    check("rst_pool_act",   64'(bus.pool_act),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single directed window, back-to-back beats, then 5 cycles of backpressure
    beat[0][0] = 8'd4;  beat[0][1] = 8'hFC;
    beat[1][0] = 8'd8;  beat[1][1] = 8'hFC;
    beat[2][0] = 8'd12; beat[2][1] = 8'hFC;
    beat[3][0] = 8'd16; beat[3][1] = 8'hFD;
    pvs = pv_count;
    start_job(1);
    check("single_busy",     64'(bus.busy),     64'd1);
    check("single_in_ready", 64'(bus.in_ready), 64'd1);
    send_beats(0, WIN);
    check("t1_pool_valid", 64'(bus.pool_valid), 64'd1);
    check("t1_in_ready",   64'(bus.in_ready),   64'd0);
    check("t1_pool_act",   64'(bus.pool_act),   64'(exp_act()));
    tick();
    check("t2_pool_valid", 64'(bus.pool_valid), 64'd0);
    check("t2_out_valid",  64'(bus.out_valid),  64'd0);
    check("t2_in_ready",   64'(bus.in_ready),   64'd0);
    tick();
    check("t3_out_valid",  64'(bus.out_valid),  64'd1);
    check("single_out_literal", 64'(bus.out_data), 64'h0000_0000_0000_FC0A);
    finish_window(5, 1'b1);
    check("single_pv_count", 64'(pv_count - pvs), 64'd1);
    tick();
    check("single_done_drop", 64'(bus.done), 64'd0);
    check("single_busy_low",  64'(bus.busy), 64'd0);

    // Zero-window job
    pvs = pv_count;
    start_job(0);
    check("zero_done",     64'(bus.done),     64'd1);
    check("zero_busy",     64'(bus.busy),     64'd0);
    check("zero_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("zero_done_drop", 64'(bus.done),     64'd0);
    check("zero_busy2",     64'(bus.busy),     64'd0);
    check("zero_in_ready2", 64'(bus.in_ready), 64'd0);
    check("zero_no_fire",   64'(pv_count),     64'(pvs));

    // Three random windows with input gaps and a stray start mid-job
    pvs = pv_count;
    dcs = done_count;
    start_job(3);
    for (int w = 0; w < 3; w++) begin
      rand_window();
      if (w == 1) begin
        bus.start       = 1'b1;
        bus.num_windows = CNT_W'(1);
        tick();
        bus.start = 1'b0;
        check("stray_start_busy", 64'(bus.busy), 64'd1);
      end
      send_beats(3, WIN);
      check("multi_pool_act", 64'(bus.pool_act), 64'(exp_act()));
      wait_out();
      finish_window($urandom_range(0, 2), w == 2);
    end
    tick();
    check("multi_pv_count",   64'(pv_count - pvs),   64'd3);
    check("multi_done_count", 64'(done_count - dcs), 64'd1);

    // Reset mid-FILL aborts silently; the next job sees only fresh data
    dcs = done_count;
    rand_window();
    start_job(1);
    send_beats(1, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",       64'(bus.busy),       64'd0);
    check("mid_rst_done",       64'(bus.done),       64'd0);
    check("mid_rst_in_ready",   64'(bus.in_ready),   64'd0);
    check("mid_rst_pool_valid", 64'(bus.pool_valid), 64'd0);
    check("mid_rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("mid_rst_out_data",   64'(bus.out_data),   64'd0);
    check("mid_rst_pool_act",   64'(bus.pool_act),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_rst_no_done", 64'(done_count), 64'(dcs));
    rand_window();
    start_job(1);
    send_beats(2, WIN);
    check("post_rst_pool_act", 64'(bus.pool_act), 64'(exp_act()));
    wait_out();
    finish_window(1, 1'b1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
